// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers, burst-limited and FULL-throttled.
// Optional per-producer accepted-word counters are built when FIFO_WR_ARB_CNT_EN is defined.
module fifo_wr_arbiter #(
    parameter int DATA_BIT  = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_BIT   = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ0,
    input  logic                REQ1,
    input  logic [DATA_BIT-1:0] DIN0,
    input  logic [DATA_BIT-1:0] DIN1,
    output logic                ACK0,
    output logic                ACK1,
    input  logic                FIFO_FULL,
    output logic                FIFO_WEN,
    output logic [DATA_BIT-1:0] FIFO_DIN,
    output logic [1:0]          GNT,
    output logic [CNT_BIT-1:0]  CNT0,
    output logic [CNT_BIT-1:0]  CNT1
);

    localparam int BEAT_BIT = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_BIT-1:0] BEAT_LAST = BEAT_BIT'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [BEAT_BIT-1:0] beat_q, beat_d;
    logic [1:0]          ack;
    logic                own_req, oth_req;
    state_t              oth_state;

    // Outputs are combinational so a beat, and its gating by FULL/RST, happens in the same cycle.
    assign ack[0]   = (state_q == OWN0) & REQ0 & ~FIFO_FULL & ~RST;
    assign ack[1]   = (state_q == OWN1) & REQ1 & ~FIFO_FULL & ~RST;
    assign ACK0     = ack[0];
    assign ACK1     = ack[1];
    assign FIFO_WEN = |ack;
    assign FIFO_DIN = ack[0] ? DIN0 : (ack[1] ? DIN1 : '0);
    assign GNT      = {state_q == OWN1, state_q == OWN0};

    assign own_req   = (state_q == OWN1) ? REQ1 : REQ0;
    assign oth_req   = (state_q == OWN1) ? REQ0 : REQ1;
    assign oth_state = (state_q == OWN1) ? OWN0 : OWN1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (REQ0 && REQ1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (REQ0) begin
                    state_d = OWN0;
                end else if (REQ1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    state_d = oth_req ? oth_state : IDLE;
                end else if (!FIFO_FULL) begin
                    // Burst boundary: the counter restarts whether or not ownership moves.
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        if (oth_req) begin
                            state_d = oth_state;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_d != state_q) && (state_d != IDLE)) begin
            last_d = (state_d == OWN1);
            beat_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

`ifdef FIFO_WR_ARB_CNT_EN
    logic [CNT_BIT-1:0] cnt_q [2];

    // Saturating accepted-word counters, one per producer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge CLK) begin
                if (RST) begin
                    cnt_q[gi] <= '0;
                end else if (ack[gi] && (cnt_q[gi] != {CNT_BIT{1'b1}})) begin
                    cnt_q[gi] <= cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign CNT0 = cnt_q[0];
    assign CNT1 = cnt_q[1];
`else
    assign CNT0 = '0;
    assign CNT1 = '0;
`endif

endmodule
